seq_frame_sync: RTL
===================

Name: seq_frame_sync

Overview:
- Downstream consumer of the serial bit produced by the one-hot sequence generator, which emits a fixed 7-bit periodic pattern.
- Acquires frame alignment on that bit stream and tracks lock with a HUNT/PRESYNC/SYNC state machine.
- Reports bit phase, frame boundaries and bit errors.
- Used as the self-check / alignment stage for the generator in system test.

Parameters:
- PERIOD, 7, pattern length in bits (2..16).
- PATTERN, 7'b1101000, expected pattern; MSB is the first bit of a frame.
- LOCK_COUNT, 2, consecutive clean frames, counting the acquisition window, needed to enter SYNC.
- LOSS_COUNT, 2, consecutive errored frames in SYNC needed to drop back to HUNT.
- CNT_W, 16, width of the saturating error counter.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- din  in  1  serial bit from the upstream generator (its y[0]).
- din_valid  in  1  din is sampled only when high.
- locked  out  1  high while in SYNC.
- sync_state  out  2  00=HUNT, 01=PRESYNC, 10=SYNC.
- phase  out  $clog2(PERIOD)  index of the next expected bit in the frame; 0 when not aligned.
- frame_done  out  1  one-cycle pulse when the last bit of an aligned frame is accepted.
- err_bit  out  1  one-cycle pulse on a mismatched bit while in SYNC.
- err_count  out  CNT_W  total SYNC bit errors, saturating.

Behaviour:
- Reset (reset=0, asynchronous) clears everything:
  - sync_state=HUNT, locked=0, phase=0, frame_done=0, err_bit=0, err_count=0.
  - Shift register, match counter, miss counter and frame-error flag all 0.
- All outputs are registered. Effects of a bit sampled on edge N are visible after edge N.
- din_valid=0: no state, counter or phase changes; frame_done=0, err_bit=0.
- Shift register sr holds the last PERIOD-1 valid bits. window = {sr, din}.
- HUNT:
  - Each valid bit shifts into sr.
  - If window==PATTERN: go to PRESYNC, phase<=0, match_cnt<=1, frame-error flag cleared.
  - No err_bit pulses are generated in HUNT.
- Expected bit in PRESYNC and SYNC: exp = PATTERN[PERIOD-1-phase].
- Phase stepping: each valid bit advances phase by 1, wrapping PERIOD-1 -> 0. The wrap asserts frame_done.
- PRESYNC:
  - A mismatch goes to HUNT immediately: phase<=0, match_cnt<=0, no err_bit.
  - On a clean frame wrap, match_cnt increments. When it reaches LOCK_COUNT, go to SYNC and set locked=1 with the same edge.
  - If LOCK_COUNT==1, the HUNT match goes directly to SYNC.
- SYNC:
  - A mismatch pulses err_bit, increments err_count (saturating at all-ones) and sets the frame-error flag.
  - At frame wrap, including a mismatch on the wrap bit itself:
    - Errored frame: miss_cnt++.
    - Clean frame: miss_cnt<=0.
    - Flag is cleared.
  - When miss_cnt reaches LOSS_COUNT: go to HUNT, locked<=0, phase<=0, miss_cnt<=0.
  - frame_done still pulses for that final frame.
- sr keeps shifting in all states. Re-acquisition after loss can therefore match on the first valid bit back in HUNT.
- err_count only clears on reset; it persists across loss/relock.
- Reset asserted mid-frame returns to HUNT at once. The partial frame is discarded, with no pulses.

Test Plan:
1. Reset, then continuous din = 1101000 repeated with din_valid=1:
   - PRESYNC after bit 7; SYNC (locked=1) after bit 14; phase = 1 after bit 15.
   - frame_done pulses after bits 14, 21, 28…; err_count=0.
2. Locked; invert one bit mid-frame (e.g. bit 3 of a frame):
   - Exactly one err_bit pulse; err_count=1; locked stays 1.
   - Following clean frame resets the miss count.
3. Locked; one bit error in each of two consecutive frames:
   - err_count=2; locked drops to 0 after the second frame's last bit; sync_state=HUNT.
   - Clean stream relocks after a further 7+7 bits at most.
4. Stream with din_valid toggled 1,0,0,1… (gaps of 1–3 cycles):
   - Identical lock timing counted in valid bits; no pulses on invalid cycles; phase frozen during gaps.
5. In PRESYNC, inject a mismatch:
   - Immediate HUNT, no err_bit, err_count unchanged.
6. CNT_W=4, locked, 20 single-bit errors spaced so loss never triggers (one error every other frame):
   - err_count saturates at 15.
   - Assert reset mid-frame: all outputs return to reset values immediately (asynchronously).

Source files
------------

// File: rtl/seq_frame_sync.sv
// Frame aligner for the periodic generator bit stream: hunts for the pattern,
// confirms lock over consecutive clean frames, then tracks bit errors while in sync.
`timescale 1ns/1ps
module seq_frame_sync #(
    parameter int                PERIOD     = 7,
    parameter logic [PERIOD-1:0] PATTERN    = 7'b1101000,
    parameter int                LOCK_COUNT = 2,
    parameter int                LOSS_COUNT = 2,
    parameter int                CNT_W      = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      din,
    input  logic                      din_valid,
    output logic                      locked,
    output logic [1:0]                sync_state,
    output logic [$clog2(PERIOD)-1:0] phase,
    output logic                      frame_done,
    output logic                      err_bit,
    output logic [CNT_W-1:0]          err_count
);
    localparam int PH_W = $clog2(PERIOD);
    localparam int MC_W = $clog2(LOCK_COUNT + 1);
    localparam int LS_W = $clog2(LOSS_COUNT + 1);

    typedef enum logic [1:0] {
        HUNT    = 2'b00,
        PRESYNC = 2'b01,
        SYNC    = 2'b10
    } state_t;

    function automatic logic [PERIOD-1:0] reverse_bits(input logic [PERIOD-1:0] v);
        logic [PERIOD-1:0] r;
        for (int i = 0; i < PERIOD; i++) begin
            r[i] = v[PERIOD-1-i];
        end
        return r;
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (c == {CNT_W{1'b1}}) ? c : c + CNT_W'(1);
    endfunction

    // Reversed so that the frame phase indexes the expected bit directly.
    localparam logic [PERIOD-1:0] PAT_REV = reverse_bits(PATTERN);

    state_t            state;
    logic [PERIOD-2:0] sr;
    logic [MC_W-1:0]   match_cnt;
    logic [LS_W-1:0]   miss_cnt;
    logic              frame_err;

    logic [PERIOD-1:0] window;
    logic              exp_bit;
    logic              mismatch;
    logic              wrap;
    logic [PH_W-1:0]   phase_nxt;

    assign window     = {sr, din};
    assign exp_bit    = PAT_REV[phase];
    assign mismatch   = (din != exp_bit);
    assign wrap       = (phase == PH_W'(PERIOD - 1));
    assign phase_nxt  = wrap ? '0 : phase + PH_W'(1);
    assign sync_state = state;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= HUNT;
            locked     <= 1'b0;
            phase      <= '0;
            frame_done <= 1'b0;
            err_bit    <= 1'b0;
            err_count  <= '0;
            sr         <= '0;
            match_cnt  <= '0;
            miss_cnt   <= '0;
            frame_err  <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            err_bit    <= 1'b0;
            if (din_valid) begin
                // sr shifts in every state so a fresh match is possible right after loss
                sr <= window[PERIOD-2:0];
                case (state)
                    HUNT: begin
                        if (window == PATTERN) begin
                            phase     <= '0;
                            match_cnt <= MC_W'(1);
                            miss_cnt  <= '0;
                            frame_err <= 1'b0;
                            if (LOCK_COUNT <= 1) begin
                                state  <= SYNC;
                                locked <= 1'b1;
                            end else begin
                                state  <= PRESYNC;
                            end
                        end
                    end
                    PRESYNC: begin
                        if (mismatch) begin
                            state     <= HUNT;
                            phase     <= '0;
                            match_cnt <= '0;
                        end else begin
                            phase <= phase_nxt;
                            if (wrap) begin
                                frame_done <= 1'b1;
                                match_cnt  <= match_cnt + MC_W'(1);
                                if (match_cnt == MC_W'(LOCK_COUNT - 1)) begin
                                    state    <= SYNC;
                                    locked   <= 1'b1;
                                    miss_cnt <= '0;
                                end
                            end
                        end
                    end
                    SYNC: begin
                        phase <= phase_nxt;
                        if (mismatch) begin
                            err_bit   <= 1'b1;
                            err_count <= sat_inc(err_count);
                        end
                        if (wrap) begin
                            // A mismatch on the wrap bit itself still marks this frame errored.
                            frame_done <= 1'b1;
                            frame_err  <= 1'b0;
                            if (frame_err || mismatch) begin
                                if (miss_cnt == LS_W'(LOSS_COUNT - 1)) begin
                                    state     <= HUNT;
                                    locked    <= 1'b0;
                                    phase     <= '0;
                                    miss_cnt  <= '0;
                                    match_cnt <= '0;
                                end else begin
                                    miss_cnt <= miss_cnt + LS_W'(1);
                                end
                            end else begin
                                miss_cnt <= '0;
                            end
                        end else if (mismatch) begin
                            frame_err <= 1'b1;
                        end
                    end
                    default: begin
                        state  <= HUNT;
                        locked <= 1'b0;
                        phase  <= '0;
                    end
                endcase
            end
        end
    end

endmodule
